key_led_mode_ctrl: RTL and testbench

//  Controller that sequences the key-to-LED register path. Synchronises and debounces the raw key
//  (key_in, active-low: 0 = pressed). Each qualified press steps a 3-state mode FSM: OFF -> ON -> BLINK -> OFF.

---
 rtl/key_led_mode_ctrl_if.sv | 22 ++
 rtl/key_led_mode_ctrl.sv | 136 +++++++++++++
 tb/tb_key_led_mode_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/key_led_mode_ctrl_if.sv
// Key/LED pin bundle between the board pins and the mode controller.
// The master side drives the raw key; the slave side (the controller) drives the LED and status.
interface key_led_mode_ctrl_if;
    logic       key_in;    // raw key, 0 = pressed, asynchronous to the system clock
    logic       led_out;   // LED drive, 1 = on
    logic [1:0] mode;      // 00 OFF, 01 ON, 10 BLINK
    logic       key_flag;  // one-cycle pulse per qualified press

    modport master (
        output key_in,
        input  led_out,
        input  mode,
        input  key_flag
    );

    modport slave (
        input  key_in,
        output led_out,
        output mode,
        output key_flag
    );
endinterface

// File: rtl/key_led_mode_ctrl.sv
// Key-to-LED mode controller.
// Synchronises and debounces an active-low key. Each qualified press steps the mode FSM
// OFF -> ON -> BLINK -> OFF. The LED is off in OFF, on in ON, and toggles every CNT_BLINK
// cycles in BLINK. All outputs are registered.
module key_led_mode_ctrl #(
    parameter int CNT_DEBOUNCE = 1_000_000,  // consecutive low cycles that qualify a press (min 2)
    parameter int CNT_BLINK    = 25_000_000  // cycles per LED half-period in BLINK (min 2)
) (
    input  logic                 sys_clock,
    input  logic                 sys_reset_n,
    key_led_mode_ctrl_if.slave   bus
);

    localparam int DEB_W = $clog2(CNT_DEBOUNCE + 1);
    localparam int BLK_W = $clog2(CNT_BLINK);

    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(CNT_DEBOUNCE);
    localparam logic [DEB_W-1:0] DEB_FIRE = DEB_W'(CNT_DEBOUNCE - 1);
    localparam logic [BLK_W-1:0] BLK_MAX  = BLK_W'(CNT_BLINK - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    // Synchroniser and debounce state
    logic             r_sync1;
    logic             r_sync2;
    logic [DEB_W-1:0] r_deb_cnt;
    logic             r_key_flag;
    logic             w_key_s;

    // FSM and LED state
    mode_e            r_mode;
    mode_e            w_mode_next;
    logic             r_led;
    logic             w_led_next;
    logic [BLK_W-1:0] r_blk_cnt;
    logic [BLK_W-1:0] w_blk_next;

    assign w_key_s = r_sync2;

    // Two-flop synchroniser; resets to the released level so a held key must requalify after reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.key_in;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: count consecutive low samples, saturate, and pulse once on reaching the threshold.
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_deb_cnt  <= '0;
            r_key_flag <= 1'b0;
        end else begin
            if (w_key_s) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt != DEB_MAX) begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
            r_key_flag <= !w_key_s && (r_deb_cnt == DEB_FIRE);
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_mode <= MODE_OFF;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    // FSM next-state: each qualified press advances the mode; the unused encoding recovers to OFF.
    // NOTE: a default assignment at the top of every combinational block prevents latch inference.
    always_comb begin
        w_mode_next = r_mode;
        unique case (r_mode)
            MODE_OFF:     if (r_key_flag) w_mode_next = MODE_ON;
            MODE_ON:      if (r_key_flag) w_mode_next = MODE_BLINK;
            MODE_BLINK:   if (r_key_flag) w_mode_next = MODE_OFF;
            MODE_ILLEGAL: w_mode_next = MODE_OFF;
            default:      w_mode_next = MODE_OFF;
        endcase
    end

    // FSM outputs: next LED level and blink count. A press in BLINK beats a simultaneous wrap.
    always_comb begin
        w_led_next = 1'b0;
        w_blk_next = '0;
        unique case (r_mode)
            MODE_OFF: begin
                w_led_next = r_key_flag;
            end
            MODE_ON: begin
                w_led_next = 1'b1;
            end
            MODE_BLINK: begin
                if (r_key_flag) begin
                    w_led_next = 1'b0;
                end else if (r_blk_cnt == BLK_MAX) begin
                    w_led_next = !r_led;
                end else begin
                    w_led_next = r_led;
                    w_blk_next = r_blk_cnt + BLK_W'(1);
                end
            end
            default: begin
                w_led_next = 1'b0;
            end
        endcase
    end

    // Registered LED drive and blink counter.
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_led     <= 1'b0;
            r_blk_cnt <= '0;
        end else begin
            r_led     <= w_led_next;
            r_blk_cnt <= w_blk_next;
        end
    end

    assign bus.led_out  = r_led;
    assign bus.mode     = r_mode;
    assign bus.key_flag = r_key_flag;

endmodule

// File: tb/tb_key_led_mode_ctrl.sv
// Directed bench for key_led_mode_ctrl with CNT_DEBOUNCE=4, CNT_BLINK=10 and a 20 ns clock.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_key_led_mode_ctrl;

    localparam int DEB = 4;
    localparam int BLK = 10;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    key_led_mode_ctrl_if u_if ();

    key_led_mode_ctrl #(
        .CNT_DEBOUNCE (DEB),
        .CNT_BLINK    (BLK)
    ) dut (
        .sys_clock   (clk),
        .sys_reset_n (rst_n),
        .bus         (u_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Advance n rising edges, leaving time 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the key low for the 7 edges a press needs to change mode, then release it.
    task automatic press();
        u_if.key_in = 1'b0;
        tick(DEB + 3);
        u_if.key_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        u_if.key_in = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) begin
            #5;
            u_if.key_in = 1'($urandom_range(0, 1));
            tests_run++;
            if (u_if.led_out !== 1'b0 || u_if.mode !== 2'b00 || u_if.key_flag !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: led=%b mode=%b flag=%b expected led=0 mode=00 flag=0",
                         i, u_if.led_out, u_if.mode, u_if.key_flag);
            end
        end
        u_if.key_in = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick(3);
        tests_run++;
        if (u_if.led_out !== 1'b0 || u_if.mode !== 2'b00 || u_if.key_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: led=%b mode=%b flag=%b expected led=0 mode=00 flag=0",
                     u_if.led_out, u_if.mode, u_if.key_flag);
        end
    endtask

    task automatic test_bounce();
        for (int r = 0; r < 5; r++) begin
            u_if.key_in = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick(1);
                tests_run++;
                if (u_if.key_flag !== 1'b0 || u_if.mode !== 2'b00) begin
                    tests_failed++;
                    $display("FAIL bounce[%0d.%0d]: flag=%b mode=%b expected flag=0 mode=00",
                             r, i, u_if.key_flag, u_if.mode);
                end
            end
            u_if.key_in = 1'b1;
            tick(1);
        end
        tick(4);
        tests_run++;
        if (u_if.key_flag !== 1'b0 || u_if.mode !== 2'b00 || u_if.led_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL bounce_end: flag=%b mode=%b led=%b expected flag=0 mode=00 led=0",
                     u_if.key_flag, u_if.mode, u_if.led_out);
        end
    endtask

    task automatic test_clean_press();
        logic       exp_flag;
        logic [1:0] exp_mode;
        logic       exp_led;
        u_if.key_in = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            exp_flag = (i == DEB + 2);
            exp_mode = (i >= DEB + 3) ? 2'b01 : 2'b00;
            exp_led  = (i >= DEB + 3);
            tests_run++;
            if (u_if.key_flag !== exp_flag || u_if.mode !== exp_mode || u_if.led_out !== exp_led) begin
                tests_failed++;
                $display("FAIL clean_press[edge %0d]: flag=%b mode=%b led=%b expected flag=%b mode=%b led=%b",
                         i, u_if.key_flag, u_if.mode, u_if.led_out, exp_flag, exp_mode, exp_led);
            end
        end
        u_if.key_in = 1'b1;
        tick(4);
    endtask

    task automatic test_mode_cycle();
        logic exp_led;
        press();
        tests_run++;
        if (u_if.mode !== 2'b10 || u_if.led_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL enter_blink: mode=%b led=%b expected mode=10 led=1", u_if.mode, u_if.led_out);
        end
        for (int j = 1; j <= 20; j++) begin
            tick(1);
            exp_led = (j < BLK) ? 1'b1 : (j < 2 * BLK) ? 1'b0 : 1'b1;
            tests_run++;
            if (u_if.led_out !== exp_led || u_if.mode !== 2'b10) begin
                tests_failed++;
                $display("FAIL blink[+%0d]: led=%b mode=%b expected led=%b mode=10",
                         j, u_if.led_out, u_if.mode, exp_led);
            end
        end
        press();
        tests_run++;
        if (u_if.mode !== 2'b00 || u_if.led_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL blink_to_off: mode=%b led=%b expected mode=00 led=0", u_if.mode, u_if.led_out);
        end
        tick(4);
    endtask

    task automatic test_async_reset();
        press();
        tick(4);
        press();
        tick(3);
        tests_run++;
        if (u_if.mode !== 2'b10) begin
            tests_failed++;
            $display("FAIL pre_reset_mode: mode=%b expected 10", u_if.mode);
        end
        #5;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (u_if.mode !== 2'b00 || u_if.led_out !== 1'b0 || u_if.key_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: mode=%b led=%b flag=%b expected mode=00 led=0 flag=0",
                     u_if.mode, u_if.led_out, u_if.key_flag);
        end
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick(5);
        tests_run++;
        if (u_if.mode !== 2'b00 || u_if.led_out !== 1'b0 || u_if.key_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_reset: mode=%b led=%b flag=%b expected mode=00 led=0 flag=0",
                     u_if.mode, u_if.led_out, u_if.key_flag);
        end
    endtask

    task automatic test_collision();
        press();
        tick(4);
        press();
        // Now 1 ns past the edge that entered BLINK (E); wraps fall on E+10 and E+20.
        tick(13);
        u_if.key_in = 1'b0;
        tick(DEB + 2);
        tests_run++;
        if (u_if.key_flag !== 1'b1 || u_if.mode !== 2'b10 || u_if.led_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL collision_pre: flag=%b mode=%b led=%b expected flag=1 mode=10 led=0",
                     u_if.key_flag, u_if.mode, u_if.led_out);
        end
        tick(1);
        tests_run++;
        if (u_if.mode !== 2'b00 || u_if.led_out !== 1'b0 || dut.r_blk_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL collision: mode=%b led=%b blk_cnt=%0d expected mode=00 led=0 blk_cnt=0",
                     u_if.mode, u_if.led_out, dut.r_blk_cnt);
        end
        u_if.key_in = 1'b1;
        tick(4);
        tests_run++;
        if (u_if.mode !== 2'b00 || u_if.led_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL collision_hold: mode=%b led=%b expected mode=00 led=0", u_if.mode, u_if.led_out);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        u_if.key_in  = 1'b1;
        test_reset();
        test_bounce();
        test_clean_press();
        test_mode_cycle();
        test_async_reset();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
